// File: rtl/axi_lib_pkg.sv
// rtl/axi_lib_pkg.sv - shared AXI widths and the trx_t request record
package axi_lib;

    localparam int AXI_ID_WIDTH   = 2;
    localparam int AXI_ADDR_WIDTH = 32;
    localparam int AXI_DATA_WIDTH = 256;
    localparam int ADDR_LSB       = $clog2(AXI_DATA_WIDTH / 8);
    localparam int MASK_WIDTH     = AXI_DATA_WIDTH / 16;
    localparam int RD_DATA_DEPTH  = 64;

    // Each mask bit covers one 16-bit lane of data.
    typedef struct packed {
        logic                      is_rd;
        logic [AXI_ADDR_WIDTH-1:0] addr;
        logic [MASK_WIDTH-1:0]     mask;
        logic [AXI_DATA_WIDTH-1:0] data;
    } trx_t;

endpackage

// File: rtl/trx_axi_master_if.sv
// rtl/trx_axi_master_if.sv - single-beat AXI4 master port bundle
interface trx_axi_master_if #(
    parameter int ID_WIDTH = axi_lib::AXI_ID_WIDTH
);
    logic [ID_WIDTH-1:0]                   m_awid;
    logic [axi_lib::AXI_ADDR_WIDTH-1:0]    m_awaddr;
    logic                                  m_awvalid;
    logic                                  m_awready;
    logic [axi_lib::AXI_DATA_WIDTH-1:0]    m_wdata;
    logic [axi_lib::AXI_DATA_WIDTH/8-1:0]  m_wstrb;
    logic                                  m_wvalid;
    logic                                  m_wready;
    logic [1:0]                            m_bresp;
    logic                                  m_bvalid;
    logic                                  m_bready;
    logic [ID_WIDTH-1:0]                   m_arid;
    logic [axi_lib::AXI_ADDR_WIDTH-1:0]    m_araddr;
    logic                                  m_arvalid;
    logic                                  m_arready;
    logic [axi_lib::AXI_DATA_WIDTH-1:0]    m_rdata;
    logic [1:0]                            m_rresp;
    logic                                  m_rvalid;
    logic                                  m_rready;

    modport master (
        output m_awid, m_awaddr, m_awvalid, input m_awready,
        output m_wdata, m_wstrb, m_wvalid, input m_wready,
        input m_bresp, m_bvalid, output m_bready,
        output m_arid, m_araddr, m_arvalid, input m_arready,
        input m_rdata, m_rresp, m_rvalid, output m_rready
    );

    modport slave (
        input m_awid, m_awaddr, m_awvalid, output m_awready,
        input m_wdata, m_wstrb, m_wvalid, output m_wready,
        output m_bresp, m_bvalid, input m_bready,
        input m_arid, m_araddr, m_arvalid, output m_arready,
        output m_rdata, m_rresp, m_rvalid, input m_rready
    );

endinterface

// File: rtl/trx_axi_master.sv
// rtl/trx_axi_master.sv - replays trx_t requests as single-beat AXI4 transactions
module trx_axi_master
    import axi_lib::*;
#(
    parameter int ID_WIDTH  = AXI_ID_WIDTH,
    parameter int TRX_ID    = 0,
    parameter int RSP_DEPTH = RD_DATA_DEPTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  trx_t                      req_trx,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [AXI_DATA_WIDTH-1:0] rsp_data,
    output logic                      err_sticky,
    trx_axi_master_if.master          m
);

    localparam int PW = $clog2(RSP_DEPTH);
    localparam logic [AXI_ADDR_WIDTH-1:0] LSB_MASK = AXI_ADDR_WIDTH'((1 << ADDR_LSB) - 1);

    typedef enum logic [2:0] {IDLE, WR, WR_B, RD_AR, RD_R} state_t;

    state_t                      state_q, state_d;
    logic                        aw_done_q, aw_done_d;
    logic                        w_done_q, w_done_d;
    logic [AXI_ADDR_WIDTH-1:0]   addr_q;
    logic [AXI_DATA_WIDTH-1:0]   data_q;
    logic [AXI_DATA_WIDTH/8-1:0] strb_q, strb_exp;
    logic                        err_q, err_set;
    logic                        accept, push, pop;
    logic [PW-1:0]               wr_ptr, rd_ptr;
    logic [PW:0]                 count;
    logic [AXI_DATA_WIDTH-1:0]   mem [RSP_DEPTH];

    // A read is admitted only when its response is guaranteed a FIFO slot.
    assign req_ready = (state_q == IDLE) && !rst &&
                       (!req_trx.is_rd || (count < (PW+1)'(RSP_DEPTH)));
    assign accept    = req_valid && req_ready;
    assign rsp_valid = (count != '0);
    assign pop       = rsp_valid && rsp_ready;
    assign rsp_data  = mem[rd_ptr];
    assign err_sticky = err_q;

    assign m.m_awid    = ID_WIDTH'(TRX_ID);
    assign m.m_arid    = ID_WIDTH'(TRX_ID);
    assign m.m_awaddr  = addr_q;
    assign m.m_araddr  = addr_q;
    assign m.m_wdata   = data_q;
    assign m.m_wstrb   = strb_q;
    assign m.m_awvalid = (state_q == WR) && !aw_done_q;
    assign m.m_wvalid  = (state_q == WR) && !w_done_q;
    assign m.m_bready  = (state_q == WR_B);
    assign m.m_arvalid = (state_q == RD_AR);
    assign m.m_rready  = (state_q == RD_R);

    always_comb begin
        strb_exp = '0;
        for (int i = 0; i < MASK_WIDTH; i++) begin
            strb_exp[2*i +: 2] = {2{req_trx.mask[i]}};
        end
    end

    always_comb begin
        state_d   = state_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        push      = 1'b0;
        err_set   = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d   = req_trx.is_rd ? RD_AR : WR;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end
            end
            WR: begin
                // AW and W may complete in either order or together.
                if (m.m_awvalid && m.m_awready) aw_done_d = 1'b1;
                if (m.m_wvalid && m.m_wready)   w_done_d  = 1'b1;
                if (aw_done_d && w_done_d)      state_d   = WR_B;
            end
            WR_B: begin
                if (m.m_bvalid) begin
                    err_set = (m.m_bresp != 2'b00);
                    state_d = IDLE;
                end
            end
            RD_AR: begin
                if (m.m_arready) state_d = RD_R;
            end
            RD_R: begin
                if (m.m_rvalid) begin
                    push    = 1'b1;
                    err_set = (m.m_rresp != 2'b00);
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            strb_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            if (accept) begin
                addr_q <= req_trx.addr & ~LSB_MASK;
                data_q <= req_trx.data;
                strb_q <= strb_exp;
            end
            if (err_set) err_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= m.m_rdata;
    end

endmodule

// File: tb/tb_trx_axi_master.sv
// tb/tb_trx_axi_master.sv - self-checking bench for trx_axi_master
module tb_trx_axi_master;
    import axi_lib::*;

    logic clk, rst;
    logic req_valid, req_ready, rsp_valid, rsp_ready, err_sticky;
    trx_t req_trx;
    logic [255:0] rsp_data;

    trx_axi_master_if #(.ID_WIDTH(2)) bus ();

    trx_axi_master #(.ID_WIDTH(2), .TRX_ID(0), .RSP_DEPTH(64)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_trx(req_trx),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .err_sticky(err_sticky), .m(bus.master)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int failures = 0;

    logic [255:0] ref_mem [logic [31:0]];
    logic [255:0] slave_mem [logic [31:0]];
    logic [255:0] exp_q [$];

    int aw_delay = 0, w_delay = 0, ar_delay = 0, b_delay = 0, r_delay = 0;
    logic [1:0] bresp_cfg = 2'b00, rresp_cfg = 2'b00;
    logic [31:0]  last_awaddr, last_araddr;
    logic [31:0]  last_wstrb;
    logic [255:0] last_wdata;
    logic [1:0]   last_awid, last_arid;

    function automatic logic [255:0] def_data(input logic [31:0] a);
        return {8{a ^ 32'hC0DE_0000}};
    endfunction

    function automatic logic [255:0] ref_rd(input logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return def_data(a);
    endfunction

    // Transactions are serialized, so applying each request at acceptance
    // gives the slave-visible memory state in order.
    function automatic void model_accept(input trx_t t);
        logic [31:0]  a;
        logic [255:0] v;
        a = t.addr & 32'hFFFF_FFE0;
        v = ref_rd(a);
        if (t.is_rd) exp_q.push_back(v);
        else begin
            for (int i = 0; i < 16; i++)
                if (t.mask[i]) v[16*i +: 16] = t.data[16*i +: 16];
            ref_mem[a] = v;
        end
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic pop_check(input string name);
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s actual=unexpected_response required=none", name);
        end else begin
            chk(name, rsp_data, exp_q[0]);
            exp_q.delete(0);
        end
    endtask

    task automatic send(input trx_t t);
        int guard;
        guard = 0;
        req_trx = t;
        req_valid = 1'b1;
        #1;
        while (!req_ready && guard < 300) begin
            tick();
            #1;
            guard++;
        end
        if (!req_ready) begin
            checks++;
            failures++;
            $display("FAIL send_timeout actual=req_ready_low required=accept");
            req_valid = 1'b0;
        end else begin
            model_accept(t);
            tick();
            req_valid = 1'b0;
        end
    endtask

    function automatic trx_t mk(input logic rd, input logic [31:0] a, input logic [15:0] mk_mask,
                                input logic [255:0] d);
        trx_t t;
        t.is_rd = rd; t.addr = a; t.mask = mk_mask; t.data = d;
        return t;
    endfunction

    function automatic trx_t rand_trx();
        trx_t t;
        t.is_rd = 1'($urandom_range(0, 1));
        t.addr  = 32'h0000_2000 + 32'($urandom_range(0, 255));
        t.mask  = 16'($urandom);
        for (int w = 0; w < 8; w++) t.data[32*w +: 32] = $urandom;
        return t;
    endfunction

    // Memory-backed AXI slave with per-channel ready/valid delays.
    initial begin : slave
        int aw_seen, w_seen, ar_seen, b_seen, r_seen;
        logic aw_got, w_got, b_pend, r_pend;
        logic [31:0] aw_a, r_a;
        logic [31:0] w_s;
        logic [255:0] w_d, cur;
        bus.m_awready = 0; bus.m_wready = 0; bus.m_bvalid = 0; bus.m_bresp = 0;
        bus.m_arready = 0; bus.m_rvalid = 0; bus.m_rresp = 0; bus.m_rdata = '0;
        aw_seen = 0; w_seen = 0; ar_seen = 0; b_seen = 0; r_seen = 0;
        aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
        aw_a = 0; r_a = 0; w_s = 0; w_d = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                aw_seen = 0; w_seen = 0; ar_seen = 0; b_seen = 0; r_seen = 0;
                aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
                bus.m_awready = 0; bus.m_wready = 0; bus.m_bvalid = 0;
                bus.m_arready = 0; bus.m_rvalid = 0;
                continue;
            end
            bus.m_bvalid = b_pend && (b_seen >= b_delay);
            bus.m_bresp  = bresp_cfg;
            if (b_pend) begin
                if (bus.m_bvalid && bus.m_bready) begin b_pend = 0; b_seen = 0; end
                else b_seen++;
            end
            bus.m_rvalid = r_pend && (r_seen >= r_delay);
            bus.m_rresp  = rresp_cfg;
            bus.m_rdata  = slave_mem.exists(r_a) ? slave_mem[r_a] : def_data(r_a);
            if (r_pend) begin
                if (bus.m_rvalid && bus.m_rready) begin r_pend = 0; r_seen = 0; end
                else r_seen++;
            end
            bus.m_awready = bus.m_awvalid && (aw_seen >= aw_delay);
            if (bus.m_awvalid) begin
                if (bus.m_awready) begin
                    aw_got = 1; aw_a = bus.m_awaddr; aw_seen = 0;
                    last_awaddr = bus.m_awaddr; last_awid = bus.m_awid;
                end else aw_seen++;
            end
            bus.m_wready = bus.m_wvalid && (w_seen >= w_delay);
            if (bus.m_wvalid) begin
                if (bus.m_wready) begin
                    w_got = 1; w_d = bus.m_wdata; w_s = bus.m_wstrb; w_seen = 0;
                    last_wdata = bus.m_wdata; last_wstrb = bus.m_wstrb;
                end else w_seen++;
            end
            if (aw_got && w_got) begin
                cur = slave_mem.exists(aw_a) ? slave_mem[aw_a] : def_data(aw_a);
                for (int b = 0; b < 32; b++)
                    if (w_s[b]) cur[8*b +: 8] = w_d[8*b +: 8];
                slave_mem[aw_a] = cur;
                aw_got = 0; w_got = 0; b_pend = 1;
            end
            bus.m_arready = bus.m_arvalid && (ar_seen >= ar_delay);
            if (bus.m_arvalid) begin
                if (bus.m_arready) begin
                    r_pend = 1; r_a = bus.m_araddr; ar_seen = 0;
                    last_araddr = bus.m_araddr; last_arid = bus.m_arid;
                end else ar_seen++;
            end
        end
    end

    typedef struct {
        logic         is_rd;
        logic [31:0]  addr;
        logic [15:0]  mask;
        logic [255:0] data;
        logic [31:0]  exp_addr;
        logic [31:0]  exp_strb;
        logic [255:0] exp_rd;
    } vec_t;

    vec_t vecs [8];

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int awv, wv, first_b, guard;
        logic acc;
        vecs[0] = '{0, 32'h0000_1234, 16'h00FF, {32{8'hA5}}, 32'h0000_1220, 32'h0000_FFFF, '0};
        vecs[1] = '{0, 32'h1FFF_FFFF, 16'h8001, {8{32'h1357_9BDF}}, 32'h1FFF_FFE0, 32'hC000_0003, '0};
        vecs[2] = '{0, 32'h0000_0000, 16'hFFFF, {8{32'h0F0F_F0F0}}, 32'h0000_0000, 32'hFFFF_FFFF, '0};
        vecs[3] = '{0, 32'h0000_0045, 16'h0000, {8{32'hFFFF_FFFF}}, 32'h0000_0040, 32'h0000_0000, '0};
        vecs[4] = '{1, 32'h0000_005F, 16'h0, '0, 32'h0000_0040, 32'h0, {8{32'hDEAD_BEEF}}};
        vecs[5] = '{1, 32'h0000_1225, 16'h0, '0, 32'h0000_1220, 32'h0,
                    {{4{32'hC0DE_1220}}, {16{8'hA5}}}};
        vecs[6] = '{1, 32'h1FFF_FFF0, 16'h0, '0, 32'h1FFF_FFE0, 32'h0,
                    {32'h1357_FFE0, {6{32'hDF21_FFE0}}, 32'hDF21_9BDF}};
        vecs[7] = '{1, 32'h0000_0000, 16'h0, '0, 32'h0000_0000, 32'h0, {8{32'h0F0F_F0F0}}};
        slave_mem[32'h40] = {8{32'hDEAD_BEEF}};
        ref_mem[32'h40]   = {8{32'hDEAD_BEEF}};

        rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
        req_trx = mk(0, 32'h0, 16'h0, '0);
        tick(); tick();
        chk("rst_req_ready", 256'(req_ready), 256'(0));
        chk("rst_valids", 256'({bus.m_awvalid, bus.m_wvalid, bus.m_arvalid, bus.m_bready, bus.m_rready}), 256'(0));
        chk("rst_rsp_err", 256'({rsp_valid, err_sticky}), 256'(0));
        chk("rst_addr", 256'(bus.m_awaddr), 256'(0));
        rst = 1'b0;
        #1;
        chk("post_rst_req_ready", 256'(req_ready), 256'(1));
        tick();

        for (int v = 0; v < 8; v++) begin
            send(mk(vecs[v].is_rd, vecs[v].addr, vecs[v].mask, vecs[v].data));
            if (!vecs[v].is_rd) begin
                chk("wr_busy_n1", 256'(req_ready), 256'(0));
                tick();
                chk("wr_busy_n2", 256'(req_ready), 256'(0));
                tick();
                chk("wr_ready_n3", 256'(req_ready), 256'(1));
                chk("awaddr", 256'(last_awaddr), 256'(vecs[v].exp_addr));
                chk("wstrb", 256'(last_wstrb), 256'(vecs[v].exp_strb));
                chk("wdata", last_wdata, vecs[v].data);
                chk("awid", 256'(last_awid), 256'(0));
            end else begin
                chk("rd_empty_n1", 256'(rsp_valid), 256'(0));
                tick();
                chk("rd_empty_n2", 256'(rsp_valid), 256'(0));
                tick();
                chk("rd_valid_n3", 256'(rsp_valid), 256'(1));
                chk("rd_data", rsp_data, vecs[v].exp_rd);
                chk("araddr", 256'(last_araddr), 256'(vecs[v].exp_addr));
                chk("arid", 256'(last_arid), 256'(0));
                rsp_ready = 1'b1;
                if (exp_q.size() > 0) exp_q.delete(0);
                tick();
                rsp_ready = 1'b0;
                chk("rd_popped", 256'(rsp_valid), 256'(0));
            end
            tick(); tick();
        end
        chk("err_clear", 256'(err_sticky), 256'(0));

        aw_delay = 5;
        send(mk(0, 32'h0000_3000, 16'h0F0F, {8{32'h2468_ACE0}}));
        awv = 0; wv = 0; first_b = -1;
        for (int k = 1; k <= 12; k++) begin
            if (bus.m_awvalid) awv++;
            if (bus.m_wvalid) wv++;
            if (bus.m_bready && first_b < 0) first_b = k;
            tick();
        end
        chk("awvalid_cycles", 256'(awv), 256'(6));
        chk("wvalid_cycles", 256'(wv), 256'(1));
        chk("bready_first", 256'(first_b), 256'(7));
        aw_delay = 0;

        bresp_cfg = 2'b10;
        send(mk(0, 32'h0000_3000, 16'h0001, {8{32'h1111_2222}}));
        tick(); tick(); tick();
        chk("err_on_bresp", 256'(err_sticky), 256'(1));
        bresp_cfg = 2'b00;
        send(mk(1, 32'h0000_3000, 16'h0, '0));
        tick(); tick();
        chk("err_hold_rd", 256'(err_sticky), 256'(1));
        rsp_ready = 1'b1;
        pop_check("err_rd_data");
        tick();
        rsp_ready = 1'b0;
        tick(); tick();
        chk("err_hold_late", 256'(err_sticky), 256'(1));

        for (int i = 0; i < 3; i++) send(mk(1, 32'h0000_5000 + 32'(i * 32), 16'h0, '0));
        r_delay = 4;
        send(mk(1, 32'h0000_5060, 16'h0, '0));
        guard = 0;
        while (!bus.m_rready && guard < 10) begin tick(); guard++; end
        chk("in_rd_r", 256'(bus.m_rready), 256'(1));
        chk("fifo3_valid", 256'(rsp_valid), 256'(1));
        rst = 1'b1;
        #1;
        chk("arst_req_ready", 256'(req_ready), 256'(0));
        chk("arst_rsp_valid", 256'(rsp_valid), 256'(0));
        chk("arst_err", 256'(err_sticky), 256'(0));
        chk("arst_valids", 256'({bus.m_awvalid, bus.m_wvalid, bus.m_arvalid, bus.m_bready, bus.m_rready}), 256'(0));
        chk("arst_addr", 256'(bus.m_araddr), 256'(0));
        exp_q.delete();
        r_delay = 0;
        tick();
        rst = 1'b0;
        req_trx = mk(1, 32'h0, 16'h0, '0);
        #1;
        chk("arst_release_ready", 256'(req_ready), 256'(1));
        tick();
        send(mk(1, 32'h0000_0040, 16'h0, '0));
        tick(); tick();
        chk("arst_new_valid", 256'(rsp_valid), 256'(1));
        rsp_ready = 1'b1;
        pop_check("arst_new_data");
        tick();
        rsp_ready = 1'b0;
        chk("arst_new_drained", 256'(rsp_valid), 256'(0));

        for (int i = 0; i < 64; i++) send(mk(1, 32'h0000_8000 + 32'(i * 32), 16'h0, '0));
        tick(); tick(); tick(); tick();
        req_trx = mk(1, 32'h0000_8800, 16'h0, '0);
        req_valid = 1'b1;
        #1;
        chk("full_blocks_rd", 256'(req_ready), 256'(0));
        tick();
        chk("full_blocks_rd2", 256'(req_ready), 256'(0));
        req_trx = mk(0, 32'h0000_9000, 16'hFFFF, {8{32'h5A5A_0001}});
        #1;
        chk("full_accepts_wr", 256'(req_ready), 256'(1));
        if (req_ready) model_accept(req_trx);
        tick();
        req_valid = 1'b0;
        tick(); tick(); tick();
        req_trx = mk(1, 32'h0000_8800, 16'h0, '0);
        req_valid = 1'b1;
        #1;
        chk("full_blocks_rd3", 256'(req_ready), 256'(0));
        rsp_ready = 1'b1;
        pop_check("full_pop0");
        tick();
        rsp_ready = 1'b0;
        #1;
        chk("after_pop_rd", 256'(req_ready), 256'(1));
        if (req_ready) model_accept(req_trx);
        tick();
        req_valid = 1'b0;
        tick(); tick(); tick();
        rsp_ready = 1'b1;
        for (int k = 0; k < 80; k++) begin
            if (rsp_valid) pop_check("full_drain");
            tick();
        end
        rsp_ready = 1'b0;
        chk("full_drain_left", 256'(exp_q.size()), 256'(0));

        for (int it = 0; it < 900; it++) begin
            if (it % 100 == 0 && it < 700) begin
                aw_delay = $urandom_range(0, 3); w_delay = $urandom_range(0, 3);
                ar_delay = $urandom_range(0, 3); b_delay = $urandom_range(0, 3);
                r_delay  = $urandom_range(0, 3);
            end
            rsp_ready = (it >= 700) ? 1'b1 : ($urandom_range(0, 3) != 0);
            if (!req_valid && it < 700 && $urandom_range(0, 2) == 0) begin
                req_valid = 1'b1;
                req_trx = rand_trx();
            end
            #1;
            if (rsp_valid && rsp_ready) pop_check("rand_rsp");
            acc = req_valid && req_ready;
            if (acc) model_accept(req_trx);
            tick();
            if (acc) req_valid = 1'b0;
        end
        chk("rand_left", 256'(exp_q.size()), 256'(0));
        chk("rand_idle_valid", 256'(rsp_valid), 256'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
